// File: rtl/poly_horner_eval.sv
// Fixed-point polynomial evaluator: NUM_MODES coefficient banks with per-bank order,
// Horner evaluation at one multiply-add per cycle behind valid/ready handshakes.
module poly_horner_eval #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int MAX_ORDER  = 15,
  parameter int NUM_MODES  = 2,
  parameter int ORDER_W    = $clog2(MAX_ORDER + 1),
  parameter int MODE_W     = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic                  cfg_sel_i,
  input  logic [MODE_W-1:0]     cfg_mode_i,
  input  logic [ORDER_W-1:0]    cfg_idx_i,
  input  logic [DATA_WIDTH-1:0] cfg_data_i,
  input  logic                  x_valid_i,
  output logic                  x_ready_o,
  input  logic [DATA_WIDTH-1:0] x_data_i,
  input  logic [MODE_W-1:0]     mode_i,
  output logic                  y_valid_o,
  input  logic                  y_ready_i,
  output logic [DATA_WIDTH-1:0] y_data_o,
  output logic                  y_sat_o
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [PW-1:0] RND =
    {{(PW - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};
  localparam logic signed [PW:0] SUM_MAX =
    {{(PW + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [PW:0] SUM_MIN =
    {{(PW + 2 - DATA_WIDTH){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] coef_q [NUM_MODES][MAX_ORDER+1];
  logic [DATA_WIDTH-1:0] coef_d [NUM_MODES][MAX_ORDER+1];
  logic [ORDER_W-1:0]    order_q [NUM_MODES];
  logic [ORDER_W-1:0]    order_d [NUM_MODES];

  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [MODE_W-1:0]     mode_q, mode_d;
  logic [ORDER_W-1:0]    cnt_q, cnt_d;
  logic                  sat_q, sat_d;

  logic                  cfg_we, accept;
  logic [ORDER_W-1:0]    order_wval;
  logic [MODE_W-1:0]     mode_sel;
  logic [ORDER_W-1:0]    new_order;
  logic [DATA_WIDTH-1:0] new_coef;
  logic [ORDER_W-1:0]    k_idx;
  logic [DATA_WIDTH-1:0] c_k;
  logic signed [PW-1:0]  prod, prod_rnd, prod_r;
  logic signed [PW:0]    sum;
  logic [DATA_WIDTH-1:0] mac_val;
  logic                  mac_clip;

  // Output process: handshake flags depend only on state and y_ready_i.
  always_comb begin
    cfg_ready_o = (state_q == IDLE);
    x_ready_o   = (state_q == IDLE) || ((state_q == DONE) && y_ready_i);
    y_valid_o   = (state_q == DONE);
  end

  assign y_data_o = acc_q;
  assign y_sat_o  = sat_q;
  assign cfg_we   = cfg_valid_i && cfg_ready_o;
  assign accept   = x_valid_i && x_ready_o;

  assign order_wval = (cfg_data_i > DATA_WIDTH'(MAX_ORDER)) ? ORDER_W'(MAX_ORDER)
                                                            : cfg_data_i[ORDER_W-1:0];

  // Out-of-range bank or index targets simply fail the guard and are dropped.
  always_comb begin
    coef_d  = coef_q;
    order_d = order_q;
    if (cfg_we && (int'(cfg_mode_i) < NUM_MODES)) begin
      if (cfg_sel_i) begin
        order_d[cfg_mode_i] = order_wval;
      end else if (int'(cfg_idx_i) <= MAX_ORDER) begin
        coef_d[cfg_mode_i][cfg_idx_i] = cfg_data_i;
      end
    end
  end

  // Accept reads the post-write tables so a same-edge config is already visible.
  assign mode_sel  = (int'(mode_i) < NUM_MODES) ? mode_i : '0;
  assign new_order = order_d[mode_sel];
  assign new_coef  = coef_d[mode_sel][new_order];

  assign k_idx    = cnt_q - ORDER_W'(1);
  assign c_k      = coef_q[mode_q][k_idx];
  assign prod     = $signed(acc_q) * $signed(x_q);
  assign prod_rnd = prod + RND;
  assign prod_r   = prod_rnd >>> FRAC_BITS;
  assign sum      = {prod_r[PW-1], prod_r} +
                    {{(PW + 1 - DATA_WIDTH){c_k[DATA_WIDTH-1]}}, c_k};

  always_comb begin
    mac_clip = 1'b1;
    if (sum > SUM_MAX) begin
      mac_val = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end else if (sum < SUM_MIN) begin
      mac_val = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end else begin
      mac_val  = sum[DATA_WIDTH-1:0];
      mac_clip = 1'b0;
    end
  end

  // Next-state process.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = (new_order != '0) ? ITER : DONE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        ITER:    if (cnt_q == ORDER_W'(1)) state_d = DONE;
        DONE:    if (y_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    x_d    = x_q;
    mode_d = mode_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    if (accept) begin
      x_d    = x_data_i;
      mode_d = mode_sel;
      acc_d  = new_coef;
      cnt_d  = new_order;
      sat_d  = 1'b0;
    end else if (state_q == ITER) begin
      acc_d = mac_val;
      cnt_d = k_idx;
      sat_d = sat_q || mac_clip;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      x_q    <= '0;
      mode_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
      for (int m = 0; m < NUM_MODES; m++) begin
        order_q[m] <= '0;
        for (int k = 0; k <= MAX_ORDER; k++) begin
          coef_q[m][k] <= '0;
        end
      end
    end else begin
      x_q     <= x_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      order_q <= order_d;
      coef_q  <= coef_d;
    end
  end

endmodule

// File: tb/tb_poly_horner_eval.sv
// Directed bench for poly_horner_eval in Q16.16 with hand-computed results,
// covering latency, rounding, saturation, back-pressure and mid-run reset.
module tb_poly_horner_eval;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_ready_o;
  logic        cfg_sel_i = 1'b0;
  logic [0:0]  cfg_mode_i = '0;
  logic [3:0]  cfg_idx_i = '0;
  logic [31:0] cfg_data_i = '0;
  logic        x_valid_i = 1'b0;
  logic        x_ready_o;
  logic [31:0] x_data_i = '0;
  logic [0:0]  mode_i = '0;
  logic        y_valid_o;
  logic        y_ready_i = 1'b0;
  logic [31:0] y_data_o;
  logic        y_sat_o;

  int checks = 0;
  int errors = 0;
  int lat;

  poly_horner_eval dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o),
    .cfg_sel_i  (cfg_sel_i),
    .cfg_mode_i (cfg_mode_i),
    .cfg_idx_i  (cfg_idx_i),
    .cfg_data_i (cfg_data_i),
    .x_valid_i  (x_valid_i),
    .x_ready_o  (x_ready_o),
    .x_data_i   (x_data_i),
    .mode_i     (mode_i),
    .y_valid_o  (y_valid_o),
    .y_ready_i  (y_ready_i),
    .y_data_o   (y_data_o),
    .y_sat_o    (y_sat_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg_wr(input logic sel, input logic [0:0] m, input logic [3:0] idx,
                        input logic [31:0] data);
    cfg_valid_i = 1'b1;
    cfg_sel_i   = sel;
    cfg_mode_i  = m;
    cfg_idx_i   = idx;
    cfg_data_i  = data;
    tick();
    cfg_valid_i = 1'b0;
  endtask

  // Waits a bounded number of edges for y_valid_o; an expired bound shows up as a latency error.
  task automatic wait_valid();
    lat = 0;
    while (!y_valid_o && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // lat is counted in edges after the accept edge; order 0 is valid right after accept.
  task automatic eval(input string tag, input logic [31:0] x, input logic [0:0] m,
                      input logic [31:0] exp_y, input logic exp_sat, input int exp_lat);
    x_valid_i = 1'b1;
    x_data_i  = x;
    mode_i    = m;
    y_ready_i = 1'b0;
    chk({tag, ".x_ready"}, {31'b0, x_ready_o}, 32'd1);
    tick();
    x_valid_i = 1'b0;
    wait_valid();
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".y"}, y_data_o, exp_y);
    chk({tag, ".sat"}, {31'b0, y_sat_o}, {31'b0, exp_sat});
    $display("eval %s x=%08h mode=%0d y=%08h sat=%0d lat=%0d", tag, x, m, y_data_o, y_sat_o, lat);
    y_ready_i = 1'b1;
    tick();
    y_ready_i = 1'b0;
    chk({tag, ".drop"}, {31'b0, y_valid_o}, 32'd0);
  endtask

  initial begin
    tick();
    chk("rst.y_valid", {31'b0, y_valid_o}, 32'd0);
    chk("rst.x_ready", {31'b0, x_ready_o}, 32'd1);
    chk("rst.cfg_ready", {31'b0, cfg_ready_o}, 32'd1);
    chk("rst.y_data", y_data_o, 32'h0);
    chk("rst.y_sat", {31'b0, y_sat_o}, 32'd0);
    rstn_i = 1'b1;
    tick();

    // 1 + x + 0.5x^2
    cfg_wr(1'b0, 1'b0, 4'd0, 32'h0001_0000);
    cfg_wr(1'b0, 1'b0, 4'd1, 32'h0001_0000);
    cfg_wr(1'b0, 1'b0, 4'd2, 32'h0000_8000);
    cfg_wr(1'b1, 1'b0, 4'd0, 32'd2);
    eval("quad_p1", 32'h0001_0000, 1'b0, 32'h0002_8000, 1'b0, 2);
    eval("quad_m1", 32'hFFFF_0000, 1'b0, 32'h0000_8000, 1'b0, 2);

    cfg_wr(1'b1, 1'b0, 4'd0, 32'd0);
    cfg_wr(1'b0, 1'b0, 4'd0, 32'h0003_0000);
    eval("order0", 32'h0001_2345, 1'b0, 32'h0003_0000, 1'b0, 0);

    // 32767*x with x=2 overflows; next operand must clear the flag
    cfg_wr(1'b1, 1'b1, 4'd0, 32'd1);
    cfg_wr(1'b0, 1'b1, 4'd1, 32'h7FFF_0000);
    cfg_wr(1'b0, 1'b1, 4'd0, 32'h0000_0000);
    eval("sat_hi", 32'h0002_0000, 1'b1, 32'h7FFF_FFFF, 1'b1, 1);
    eval("sat_clr", 32'h0001_0000, 1'b1, 32'h7FFF_0000, 1'b0, 1);

    cfg_wr(1'b0, 1'b1, 4'd1, 32'h0000_8000);
    eval("rnd_pos", 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b0, 1);
    eval("rnd_neg", 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1);

    // Back-pressure: 0.5*2.0 held for 5 cycles while a config write is attempted
    x_valid_i = 1'b1;
    x_data_i  = 32'h0002_0000;
    mode_i    = 1'b1;
    tick();
    x_valid_i = 1'b0;
    wait_valid();
    chk("hold.lat", lat, 1);
    for (int i = 0; i < 5; i++) begin
      cfg_valid_i = 1'b1;
      cfg_sel_i   = 1'b0;
      cfg_mode_i  = 1'b1;
      cfg_idx_i   = 4'd0;
      cfg_data_i  = 32'h1234_0000;
      #1;
      chk("hold.y", y_data_o, 32'h0001_0000);
      chk("hold.sat", {31'b0, y_sat_o}, 32'd0);
      chk("hold.y_valid", {31'b0, y_valid_o}, 32'd1);
      chk("hold.x_ready", {31'b0, x_ready_o}, 32'd0);
      chk("hold.cfg_ready", {31'b0, cfg_ready_o}, 32'd0);
      $display("hold cycle %0d y=%08h", i, y_data_o);
      tick();
    end
    cfg_valid_i = 1'b0;
    y_ready_i = 1'b1;
    x_valid_i = 1'b1;
    x_data_i  = 32'h0004_0000;
    #1;
    chk("b2b.x_ready", {31'b0, x_ready_o}, 32'd1);
    tick();
    y_ready_i = 1'b0;
    x_valid_i = 1'b0;
    chk("b2b.drop", {31'b0, y_valid_o}, 32'd0);
    tick();
    chk("b2b.valid", {31'b0, y_valid_o}, 32'd1);
    chk("b2b.y", y_data_o, 32'h0002_0000);
    $display("b2b y=%08h", y_data_o);
    y_ready_i = 1'b1;
    tick();
    y_ready_i = 1'b0;

    // Order 20 clamps to 15: sum of coefficients at x=1.0 is 1+0.5+1+3
    cfg_wr(1'b0, 1'b0, 4'd15, 32'h0001_0000);
    cfg_wr(1'b1, 1'b0, 4'd0, 32'd20);
    eval("clamp15", 32'h0001_0000, 1'b0, 32'h0005_8000, 1'b0, 15);

    x_valid_i = 1'b1;
    x_data_i  = 32'h0001_0000;
    mode_i    = 1'b0;
    tick();
    x_valid_i = 1'b0;
    tick();
    tick();
    #2;
    rstn_i = 1'b0;
    #1;
    chk("mid_rst.y_valid", {31'b0, y_valid_o}, 32'd0);
    chk("mid_rst.x_ready", {31'b0, x_ready_o}, 32'd1);
    chk("mid_rst.cfg_ready", {31'b0, cfg_ready_o}, 32'd1);
    chk("mid_rst.y_data", y_data_o, 32'h0);
    chk("mid_rst.y_sat", {31'b0, y_sat_o}, 32'd0);
    tick();
    rstn_i = 1'b1;
    tick();
    eval("post_rst0", 32'h0001_0000, 1'b0, 32'h0000_0000, 1'b0, 0);
    eval("post_rst1", 32'h0001_0000, 1'b1, 32'h0000_0000, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
